// File: rtl/dice_turn_controller.sv
// Turn sequencer for the dice race game: converts detected die colours into
// moves, hands the turn on when the die is removed, forfeits idle turns and declares a winner.
module dice_turn_controller #(
  parameter int NUM_PLAYERS  = 2,
  parameter int TRACK_LEN    = 30,
  parameter int RED_STEPS    = 1,
  parameter int GREEN_STEPS  = 2,
  parameter int BLUE_STEPS   = 3,
  parameter int ROLL_TIMEOUT = 0,
  parameter int POS_W        = $clog2(TRACK_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         stable_color,
  input  logic               result_ready,
  input  logic               turn_end,
  output logic [1:0]         game_state,
  output logic               detect_armed,
  output logic [1:0]         cur_player,
  output logic [4*POS_W-1:0] positions,
  output logic [2:0]         last_steps,
  output logic               move_pulse,
  output logic               turn_pulse,
  output logic               timeout_pulse,
  output logic               winner_valid,
  output logic [1:0]         winner_id
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WAIT_ROLL  = 2'b01,
    WAIT_CLEAR = 2'b10,
    WIN        = 2'b11
  } state_t;

  localparam int unsigned       NP          = NUM_PLAYERS;
  localparam int unsigned       PW          = POS_W;
  localparam logic [1:0]        LAST_PLAYER = 2'(NUM_PLAYERS - 1);
  localparam logic [POS_W-1:0]  TRACK_POS   = POS_W'(TRACK_LEN);
  localparam logic [POS_W+2:0]  TRACK_SUM   = (POS_W + 3)'(TRACK_LEN);
  localparam logic [2:0]        RED_S       = 3'(RED_STEPS);
  localparam logic [2:0]        GREEN_S     = 3'(GREEN_STEPS);
  localparam logic [2:0]        BLUE_S      = 3'(BLUE_STEPS);
  localparam logic              TIMEOUT_EN  = (ROLL_TIMEOUT > 0);
  localparam logic [31:0]       TIMEOUT_TOP = 32'(ROLL_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [1:0]       player_q, player_d;
  logic [POS_W-1:0] pos_q [4];
  logic [POS_W-1:0] pos_d [4];
  logic [2:0]       steps_q, steps_d;
  logic             move_q, move_d;
  logic             turn_q, turn_d;
  logic             tout_q, tout_d;
  logic             win_valid_q, win_valid_d;
  logic [1:0]       win_id_q, win_id_d;
  logic [31:0]      cnt_q, cnt_d;

  logic             roll_valid;
  logic [2:0]       roll_steps;
  logic [POS_W+2:0] pos_sum;
  logic [POS_W-1:0] new_pos;
  logic [1:0]       next_player;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      player_q    <= '0;
      steps_q     <= '0;
      move_q      <= 1'b0;
      turn_q      <= 1'b0;
      tout_q      <= 1'b0;
      win_valid_q <= 1'b0;
      win_id_q    <= '0;
      cnt_q       <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        pos_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      player_q    <= player_d;
      steps_q     <= steps_d;
      move_q      <= move_d;
      turn_q      <= turn_d;
      tout_q      <= tout_d;
      win_valid_q <= win_valid_d;
      win_id_q    <= win_id_d;
      cnt_q       <= cnt_d;
      for (int unsigned i = 0; i < 4; i++) begin
        pos_q[i] <= pos_d[i];
      end
    end
  end

  // Move arithmetic is evaluated every cycle and only committed on a valid roll.
  always_comb begin
    roll_valid = result_ready && (stable_color != 2'b00);
    case (stable_color)
      2'b01:   roll_steps = RED_S;
      2'b10:   roll_steps = GREEN_S;
      default: roll_steps = BLUE_S;
    endcase
    pos_sum     = {3'b000, pos_q[player_q]} + {{POS_W{1'b0}}, roll_steps};
    new_pos     = (pos_sum >= TRACK_SUM) ? TRACK_POS : pos_sum[POS_W-1:0];
    next_player = (player_q == LAST_PLAYER) ? 2'b00 : player_q + 2'd1;
  end

  always_comb begin
    state_d     = state_q;
    player_d    = player_q;
    steps_d     = steps_q;
    move_d      = 1'b0;
    turn_d      = 1'b0;
    tout_d      = 1'b0;
    win_valid_d = win_valid_q;
    win_id_d    = win_id_q;
    cnt_d       = cnt_q;
    for (int unsigned i = 0; i < 4; i++) begin
      pos_d[i] = pos_q[i];
    end

    case (state_q)
      IDLE, WIN: begin
        if (start) begin
          state_d     = WAIT_ROLL;
          player_d    = '0;
          steps_d     = '0;
          cnt_d       = '0;
          win_valid_d = 1'b0;
          for (int unsigned i = 0; i < 4; i++) begin
            pos_d[i] = '0;
          end
        end
      end

      WAIT_ROLL: begin
        // A valid roll takes priority over both turn_end and the forfeit.
        if (roll_valid) begin
          pos_d[player_q] = new_pos;
          steps_d         = roll_steps;
          move_d          = 1'b1;
          if (new_pos == TRACK_POS) begin
            state_d     = WIN;
            win_valid_d = 1'b1;
            win_id_d    = player_q;
          end else begin
            state_d = WAIT_CLEAR;
          end
        end else if (TIMEOUT_EN && (cnt_q == TIMEOUT_TOP)) begin
          tout_d   = 1'b1;
          turn_d   = 1'b1;
          player_d = next_player;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      WAIT_CLEAR: begin
        if (turn_end) begin
          state_d  = WAIT_ROLL;
          player_d = next_player;
          turn_d   = 1'b1;
          cnt_d    = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    positions = '0;
    for (int unsigned i = 0; i < NP; i++) begin
      positions[i*PW +: PW] = pos_q[i];
    end
  end

  assign game_state    = state_q;
  assign detect_armed  = (state_q == WAIT_ROLL);
  assign cur_player    = player_q;
  assign last_steps    = steps_q;
  assign move_pulse    = move_q;
  assign turn_pulse    = turn_q;
  assign timeout_pulse = tout_q;
  assign winner_valid  = win_valid_q;
  assign winner_id     = win_id_q;

endmodule
